// File: rtl/pipo_universal.sv
// Universal WIDTH-bit register: parallel load, shift/rotate/asr, clear, and a
// multi-cycle burst shift engine that reports busy/done.
module pipo_universal #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_q, w_qNext;
  logic [CNT_W-1:0] r_cnt, w_cntNext, w_lenClamped;
  logic [2:0]       r_mode, w_modeNext;
  logic             r_busy, w_busyNext;
  logic             r_done, w_doneNext;
  logic             w_isShift, w_accept;

  function automatic logic [WIDTH-1:0] applyOp(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] pin
  );
    logic [WIDTH-1:0] res;
    case (op)
      3'b001:  res = pin;
      3'b010:  res = {q[WIDTH-2:0], sl};
      3'b011:  res = {sr, q[WIDTH-1:1]};
      3'b100:  res = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b101:  res = {q[0], q[WIDTH-1:1]};
      3'b110:  res = {q[WIDTH-1], q[WIDTH-1:1]};
      3'b111:  res = '0;
      default: res = q;
    endcase
    return res;
  endfunction

  // Counter holds the number of shifts still owed after the current edge.
  always_comb begin
    w_isShift    = (mode >= 3'b010) && (mode <= 3'b110);
    w_lenClamped = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;
    w_accept     = (r_state == IDLE) && burst_start && w_isShift && (burst_len != '0);
    w_stateNext  = r_state;
    w_qNext      = r_q;
    w_cntNext    = r_cnt;
    w_modeNext   = r_mode;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    case (r_state)
      IDLE: begin
        w_qNext = applyOp(mode, r_q, serial_in_l, serial_in_r, parallel_in);
        if (w_accept) begin
          w_modeNext = mode;
          w_cntNext  = w_lenClamped - CNT_W'(1);
          if (w_lenClamped != CNT_W'(1)) begin
            w_stateNext = BURST;
            w_busyNext  = 1'b1;
          end else begin
            w_doneNext = 1'b1;
          end
        end
      end
      BURST: begin
        w_qNext   = applyOp(r_mode, r_q, serial_in_l, serial_in_r, parallel_in);
        w_cntNext = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_stateNext = IDLE;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_q     <= RESET_VALUE;
      r_cnt   <= '0;
      r_mode  <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (en) begin
      r_state <= w_stateNext;
      r_q     <= w_qNext;
      r_cnt   <= w_cntNext;
      r_mode  <= w_modeNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
    end else begin
      r_done  <= 1'b0;
    end
  end

  assign parallel_out   = r_q;
  assign serial_out_msb = r_q[WIDTH-1];
  assign serial_out_lsb = r_q[0];
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_pipo_universal.sv
// Bench for pipo_universal (WIDTH=8): directed literal checks plus random
// stimulus compared every cycle against a behavioural model.
module tb_pipo_universal;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b1;
  logic [2:0]       mode = 3'b000;
  logic [WIDTH-1:0] parallel_in = '0;
  logic             serial_in_l = 1'b0;
  logic             serial_in_r = 1'b0;
  logic             burst_start = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_msb, serial_out_lsb, busy, done;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  logic [7:0] mQ = '0;
  int         mRem = 0;
  int         mMode = 0;
  bit         mDone = 1'b0;

  pipo_universal #(.WIDTH(WIDTH), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .parallel_in(parallel_in),
    .serial_in_l(serial_in_l), .serial_in_r(serial_in_r),
    .burst_start(burst_start), .burst_len(burst_len),
    .parallel_out(parallel_out), .serial_out_msb(serial_out_msb),
    .serial_out_lsb(serial_out_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] modelOp(int op, logic [7:0] q, logic sl, logic sr, logic [7:0] pin);
    case (op)
      1: return pin;
      2: return (q << 1) | {7'b0, sl};
      3: return (q >> 1) | ({7'b0, sr} << 7);
      4: return (q << 1) | (q >> 7);
      5: return (q >> 1) | (q << 7);
      6: return (q >> 1) | (q & 8'h80);
      7: return 8'h00;
      default: return q;
    endcase
  endfunction

  // Model: a burst is simply a number of shifts still owed with a remembered mode.
  always @(posedge clk) begin
    int n;
    if (!rst) begin
      mQ = 8'h00; mRem = 0; mMode = 0; mDone = 1'b0;
    end else if (!en) begin
      mDone = 1'b0;
    end else if (mRem > 0) begin
      mQ = modelOp(mMode, mQ, serial_in_l, serial_in_r, parallel_in);
      mRem--;
      mDone = (mRem == 0);
    end else begin
      mQ = modelOp(int'(mode), mQ, serial_in_l, serial_in_r, parallel_in);
      mDone = 1'b0;
      if (burst_start && mode >= 3'd2 && mode <= 3'd6 && burst_len != 0) begin
        n = (int'(burst_len) > 8) ? 8 : int'(burst_len);
        mRem = n - 1;
        mMode = int'(mode);
        mDone = (n == 1);
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      total++;
      if (parallel_out !== mQ || serial_out_msb !== mQ[7] || serial_out_lsb !== mQ[0] ||
          busy !== (mRem > 0) || done !== mDone) begin
        bad++;
        $display("[TB] FAIL model t=%0t: got q=%h msb=%b lsb=%b busy=%b done=%b, want q=%h busy=%b done=%b",
                 $time, parallel_out, serial_out_msb, serial_out_lsb, busy, done, mQ, (mRem > 0), mDone);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] m, input logic [7:0] pin, input logic bs,
                               input logic [3:0] len, input logic e);
    mode = m; parallel_in = pin; burst_start = bs; burst_len = len; en = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expQ, input logic expBusy, input logic expDone);
    total++;
    if (parallel_out !== expQ || serial_out_msb !== expQ[7] || serial_out_lsb !== expQ[0] ||
        busy !== expBusy || done !== expDone) begin
      bad++;
      $display("[TB] FAIL %s: got q=%h msb=%b lsb=%b busy=%b done=%b, want q=%h busy=%b done=%b",
               name, parallel_out, serial_out_msb, serial_out_lsb, busy, done, expQ, expBusy, expDone);
    end
  endtask

  task automatic loadValue(input logic [7:0] v);
    applyStimulus(3'b001, v, 1'b0, 4'd0, 1'b1);
    step();
  endtask

  initial begin
    // Initial reset
    applyStimulus(3'b000, 8'h00, 1'b0, 4'd0, 1'b1);
    step();
    checkEn = 1'b1;
    rst = 1'b1;
    checkOutput("reset_init", 8'h00, 1'b0, 1'b0);

    // Synchronous reset
    loadValue(8'hA5);
    checkOutput("load_a5", 8'hA5, 1'b0, 1'b0);
    applyStimulus(3'b000, 8'h00, 1'b0, 4'd0, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    checkOutput("reset_edge", 8'h00, 1'b0, 1'b0);
    loadValue(8'hA5);
    applyStimulus(3'b000, 8'h00, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    step();
    checkOutput("reset_between_edges", 8'hA5, 1'b0, 1'b0);

    // Load, enable freeze, clear
    loadValue(8'h3C);
    checkOutput("load_3c", 8'h3C, 1'b0, 1'b0);
    applyStimulus(3'b001, 8'hFF, 1'b0, 4'd0, 1'b0);
    repeat (3) step();
    checkOutput("en_low_hold", 8'h3C, 1'b0, 1'b0);
    applyStimulus(3'b111, 8'hFF, 1'b0, 4'd0, 1'b1);
    step();
    checkOutput("clear", 8'h00, 1'b0, 1'b0);

    // Single shifts from 0x81
    loadValue(8'h81);
    serial_in_l = 1'b1; applyStimulus(3'b010, 8'h00, 1'b0, 4'd0, 1'b1); step();
    checkOutput("shl", 8'h03, 1'b0, 1'b0);
    serial_in_l = 1'b0;
    loadValue(8'h81);
    serial_in_r = 1'b0; applyStimulus(3'b011, 8'h00, 1'b0, 4'd0, 1'b1); step();
    checkOutput("shr", 8'h40, 1'b0, 1'b0);
    loadValue(8'h81);
    applyStimulus(3'b100, 8'h00, 1'b0, 4'd0, 1'b1); step();
    checkOutput("rotl", 8'h03, 1'b0, 1'b0);
    loadValue(8'h81);
    applyStimulus(3'b101, 8'h00, 1'b0, 4'd0, 1'b1); step();
    checkOutput("rotr", 8'hC0, 1'b0, 1'b0);
    loadValue(8'h81);
    applyStimulus(3'b110, 8'h00, 1'b0, 4'd0, 1'b1); step();
    checkOutput("asr", 8'hC0, 1'b0, 1'b0);

    // Burst rotl of 3, inputs disturbed while busy
    loadValue(8'h96);
    applyStimulus(3'b100, 8'h00, 1'b1, 4'd3, 1'b1); step();
    checkOutput("burst3_1", 8'h2D, 1'b1, 1'b0);
    applyStimulus(3'b001, 8'h00, 1'b1, 4'd7, 1'b1); step();
    checkOutput("burst3_2", 8'h5A, 1'b1, 1'b0);
    step();
    checkOutput("burst3_3", 8'hB4, 1'b0, 1'b1);
    applyStimulus(3'b000, 8'h00, 1'b0, 4'd0, 1'b1); step();
    checkOutput("burst3_after", 8'hB4, 1'b0, 1'b0);

    // Clamped burst of 12 with an enable pause
    loadValue(8'h96);
    applyStimulus(3'b100, 8'h00, 1'b1, 4'd12, 1'b1); step();
    checkOutput("clamp_1", 8'h2D, 1'b1, 1'b0);
    applyStimulus(3'b000, 8'h00, 1'b0, 4'd0, 1'b1);
    repeat (2) step();
    checkOutput("clamp_3", 8'hB4, 1'b1, 1'b0);
    en = 1'b0;
    step(); checkOutput("pause_1", 8'hB4, 1'b1, 1'b0);
    step(); checkOutput("pause_2", 8'hB4, 1'b1, 1'b0);
    en = 1'b1;
    repeat (4) step();
    checkOutput("clamp_7", 8'h4B, 1'b1, 1'b0);
    step();
    checkOutput("clamp_done", 8'h96, 1'b0, 1'b1);
    step();
    checkOutput("clamp_after", 8'h96, 1'b0, 1'b0);

    // Burst aborted by reset, then a one-shift burst
    loadValue(8'hFF);
    serial_in_l = 1'b0;
    applyStimulus(3'b010, 8'h00, 1'b1, 4'd5, 1'b1); step();
    checkOutput("abort_1", 8'hFE, 1'b1, 1'b0);
    applyStimulus(3'b000, 8'h00, 1'b0, 4'd0, 1'b1); step();
    checkOutput("abort_2", 8'hFC, 1'b1, 1'b0);
    rst = 1'b0; step(); rst = 1'b1;
    checkOutput("abort_reset", 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("abort_nodone", 8'h00, 1'b0, 1'b0);
    serial_in_l = 1'b1;
    applyStimulus(3'b010, 8'h00, 1'b1, 4'd1, 1'b1); step();
    checkOutput("len1_done", 8'h01, 1'b0, 1'b1);
    applyStimulus(3'b000, 8'h00, 1'b0, 4'd0, 1'b1); step();
    checkOutput("len1_after", 8'h01, 1'b0, 1'b0);

    // Random traffic checked by the model each cycle
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 9) < 3),
                    4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 85));
      serial_in_l = 1'($urandom);
      serial_in_r = 1'($urandom);
      rst = ($urandom_range(0, 59) != 0);
      step();
    end
    rst = 1'b1;
    step();

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
